corelet_ctrl: RTL and testbench
===============================

Name: corelet_ctrl

Overview:
- Sequencer that drives the 34-bit corelet instruction word for one weight-stationary layer pass.
- Pass order: weights from XMEM into L0, then kernel load into the MAC array, then activations from XMEM into L0 in tiles, then execute, then drain OFIFO results to PMEM.
- Sits between the top-level testbench/host and the corelet plus its XMEM/PMEM SRAMs; replaces hand-written per-cycle instruction streams.

Parameters:
- row, 8, MAC array rows and number of weight words loaded.
- col, 8, MAC array columns; sets the kernel-load flush length.
- tile, 64, max activation vectors per tile (L0/OFIFO depth).
- addr_bw, 11, SRAM address width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begins a pass when idle
- w_base  input  addr_bw  XMEM address of first weight word
- a_base  input  addr_bw  XMEM address of first activation vector
- p_base  input  addr_bw  PMEM address of first output vector
- len  input  addr_bw  total activation vectors in the pass
- l0_full  input  1  L0 full flag
- ofifo_valid  input  1  OFIFO has a complete row
- inst  output  34  corelet instruction word: 33 SFP_ACC, 32 CEN_PMEM, 31 WEN_PMEM, 30:20 A_PMEM, 19 CEN_XMEM, 18 WEN_XMEM, 17:7 A_XMEM, 6 OFIFO_RD, 3 L0_RD, 2 L0_WR, 1 execute, 0 kernel load
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of pass
- err  output  1  sticky overflow flag, cleared on start

Behaviour:
- Signal conventions:
  - CEN/WEN are active-low.
  - The idle word is 34'h1800C0000: CEN and WEN high, everything else 0.
  - Every bit of inst not named as driven in a state holds its idle value.
- Inputs w_base, a_base, p_base and len are captured on start.
- Reset:
  - Asynchronous; forces IDLE.
  - inst=34'h1800C0000, busy=0, done=0, err=0, all counters 0.
  - Reset mid-pass abandons the pass with no done pulse.
- The XMEM read latency is 1 cycle, so L0_WR is asserted the cycle after each XMEM read.
- States and transitions:
  - IDLE: start=1 goes to WLOAD. start while busy is ignored.
  - WLOAD, row+1 cycles:
    - Cycles 0..row-1: CEN_XMEM=0, WEN_XMEM=1, A_XMEM=w_base+k.
    - Cycles 1..row: L0_WR=1.
    - Then go to KLOAD.
  - KLOAD, row cycles: L0_RD=1, inst[0]=1. Then go to KFLUSH.
  - KFLUSH, col cycles of the idle word.
    - Then go to ALOAD, or to DONE if len=0.
  - ALOAD, n+1 cycles, where n=min(tile, remaining):
    - Reads from a_base+offset, with L0_WR delayed 1 cycle as in WLOAD.
    - l0_full=1 at the cycle of any L0_WR sets err; sequencing continues.
  - EXEC, n cycles: L0_RD=1, inst[1]=1.
  - DRAIN, until n PMEM writes are done:
    - Each cycle with ofifo_valid=1 and reads outstanding: OFIFO_RD=1.
    - The following cycle: CEN_PMEM=0, WEN_PMEM=0, A_PMEM=p_base+j, then j++.
    - After the last write: go to ALOAD if remaining>0, else DONE.
  - DONE: done=1 for 1 cycle, then go to IDLE. busy=0 from IDLE.
- Counters:
  - Offsets are addr_bw bits.
  - Address adds wrap modulo 2^addr_bw with no error.
- A simultaneous start and reset: reset wins.

Optional Feature:
- Macro CORELET_CTRL_SFP_ACC_EN.
- Defined: SFP_ACC (inst[33]) is asserted in the cycle following each PMEM write, i.e. 2 cycles after the corresponding OFIFO_RD.
- Undefined: inst[33] is tied to 0 and no SFP logic is referenced.

Test Plan:
- Assert reset mid-EXEC -> inst=34'h1800C0000 and busy=0 in the same cycle; no done pulse; a following start runs a full pass correctly.
- row=8, col=8, w_base=0, a_base=16, p_base=0, len=4, ofifo_valid held high -> expected response:
  - WLOAD: A_XMEM 0..7, with L0_WR in cycles 1..8 of WLOAD.
  - KLOAD: 8 cycles of inst[3]=1, inst[0]=1, then 8 idle cycles.
  - ALOAD: A_XMEM 16..19.
  - EXEC: 4 cycles.
  - PMEM writes to 0..3.
  - Single done pulse.
- len=150, tile=64 -> tiles of 64, 64 and 22; PMEM addresses run continuously 0..149; ALOAD of tile 2 starts only after the 64th PMEM write of tile 1.
- len=0 -> pass ends after KFLUSH; no activation XMEM reads, no OFIFO_RD, no PMEM writes; done pulses.
- In DRAIN with ofifo_valid toggling 1,0,0,1,... -> OFIFO_RD only in valid cycles, each followed by exactly one PMEM write; the write count equals n.
- l0_full=1 forced during ALOAD -> err=1 sticky through DONE; the next start clears err. Second start pulse while busy -> no effect.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer that drives the 34-bit corelet instruction word
// for one weight-stationary layer pass. The pass order is weight load,
// kernel load, kernel flush, then per activation tile: load, execute,
// and drain results to PMEM.
// Optional build macro CORELET_CTRL_SFP_ACC_EN: when defined, SFP_ACC
// (inst[33]) pulses in the cycle after each PMEM write. When undefined,
// inst[33] is tied to 0.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int tile    = 64,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [addr_bw-1:0] len,
    input  logic               l0_full,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [33:0]        IDLE_WORD = 34'h1800C0000;
    localparam logic [addr_bw-1:0] ROW_C     = addr_bw'(row);
    localparam logic [addr_bw-1:0] COL_C     = addr_bw'(col);
    localparam logic [addr_bw-1:0] TILE_C    = addr_bw'(tile);
    localparam logic [addr_bw-1:0] ONE_C     = addr_bw'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_KLOAD, S_KFLUSH, S_ALOAD, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [addr_bw-1:0] cnt_q, cnt_d;
    logic [addr_bw-1:0] n_q, n_d;
    logic [addr_bw-1:0] a_off_q, a_off_d;
    logic [addr_bw-1:0] p_off_q, p_off_d;
    logic [addr_bw-1:0] rd_q, rd_d;
    logic [addr_bw-1:0] wr_q, wr_d;
    logic [addr_bw-1:0] w_base_q, w_base_d;
    logic [addr_bw-1:0] a_base_q, a_base_d;
    logic [addr_bw-1:0] p_base_q, p_base_d;
    logic [addr_bw-1:0] len_q, len_d;
    logic               err_q, err_d;
    logic               wr_pend_q, wr_pend_d;
    logic               ofifo_rd;
    logic [addr_bw-1:0] remaining;
    logic [addr_bw-1:0] tile_n;
`ifdef CORELET_CTRL_SFP_ACC_EN
    logic               sfp_q;
`endif

    // State, counters and pass parameters captured on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            a_off_q   <= '0;
            p_off_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            w_base_q  <= '0;
            a_base_q  <= '0;
            p_base_q  <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            a_off_q   <= a_off_d;
            p_off_q   <= p_off_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            w_base_q  <= w_base_d;
            a_base_q  <= a_base_d;
            p_base_q  <= p_base_d;
            len_q     <= len_d;
            err_q     <= err_d;
            wr_pend_q <= wr_pend_d;
        end
    end

`ifdef CORELET_CTRL_SFP_ACC_EN
    // SFP accumulate trails each PMEM write by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sfp_q <= 1'b0;
        else       sfp_q <= wr_pend_q;
    end
`endif

    // Next-state, counter updates and instruction word decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        a_off_d   = a_off_q;
        p_off_d   = p_off_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;
        p_base_d  = p_base_q;
        len_d     = len_q;
        err_d     = err_q;
        ofifo_rd  = 1'b0;
        done      = 1'b0;
        inst      = IDLE_WORD;
        remaining = len_q - a_off_q;
        tile_n    = (remaining > TILE_C) ? TILE_C : remaining;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WLOAD;
                    cnt_d    = '0;
                    a_off_d  = '0;
                    p_off_d  = '0;
                    w_base_d = w_base;
                    a_base_d = a_base;
                    p_base_d = p_base;
                    len_d    = len;
                    err_d    = 1'b0;
                end
            end
            S_WLOAD: begin
                if (cnt_q < ROW_C) begin
                    inst[19]   = 1'b0;
                    inst[17:7] = 11'(w_base_q + cnt_q);
                end
                if (cnt_q != '0) inst[2] = 1'b1;
                if (cnt_q == ROW_C) begin
                    state_d = S_KLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_KLOAD: begin
                inst[3] = 1'b1;
                inst[0] = 1'b1;
                if (cnt_q == ROW_C - ONE_C) begin
                    state_d = S_KFLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_KFLUSH: begin
                if (cnt_q == COL_C - ONE_C) begin
                    cnt_d = '0;
                    n_d   = tile_n;
                    state_d = (remaining == '0) ? S_DONE : S_ALOAD;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_ALOAD: begin
                if (cnt_q < n_q) begin
                    inst[19]   = 1'b0;
                    inst[17:7] = 11'(a_base_q + a_off_q + cnt_q);
                end
                if (cnt_q != '0) begin
                    inst[2] = 1'b1;
                    if (l0_full) err_d = 1'b1;
                end
                if (cnt_q == n_q) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                    a_off_d = a_off_q + n_q;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_EXEC: begin
                inst[3] = 1'b1;
                inst[1] = 1'b1;
                if (cnt_q == n_q - ONE_C) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid && (rd_q != n_q)) begin
                    ofifo_rd = 1'b1;
                    rd_d     = rd_q + ONE_C;
                end
                inst[6] = ofifo_rd;
                // The PMEM write for each OFIFO read lands one cycle later;
                // leaving DRAIN is keyed on the last write, not the last read.
                if (wr_pend_q) begin
                    inst[32]    = 1'b0;
                    inst[31]    = 1'b0;
                    inst[30:20] = 11'(p_base_q + p_off_q);
                    p_off_d     = p_off_q + ONE_C;
                    wr_d        = wr_q + ONE_C;
                    if (wr_q == n_q - ONE_C) begin
                        cnt_d   = '0;
                        n_d     = tile_n;
                        state_d = (remaining == '0) ? S_DONE : S_ALOAD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wr_pend_d = ofifo_rd;
`ifdef CORELET_CTRL_SFP_ACC_EN
        inst[33] = sfp_q;
`endif
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl. Expected activity is generated as an
// ordered event list (XMEM reads, kernel loads, executes, PMEM writes) from
// the pass parameters; the DUT's decoded instruction stream is matched
// against it, along with the cycle-relative rules between events.
`timescale 1ns/1ps
module tb_corelet_ctrl;

    localparam int unsigned ROW    = 8;
    localparam int unsigned COL    = 8;
    localparam int unsigned TILE   = 64;
    localparam int unsigned ABW    = 11;
    localparam int unsigned AMOD   = 2048;
    localparam int          BUDGET = 4000;
    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;
    localparam logic [7:0]  EV_R = 8'h52;
    localparam logic [7:0]  EV_K = 8'h4B;
    localparam logic [7:0]  EV_E = 8'h45;
    localparam logic [7:0]  EV_W = 8'h57;

    logic           clk = 1'b0;
    logic           reset, start, l0_full, ofifo_valid;
    logic [ABW-1:0] w_base, a_base, p_base, len;
    logic [33:0]    inst;
    logic           busy, done, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  kind;
        int unsigned addr;
    } tok_t;
    tok_t exp_q[$];

    int cyc;
    int kseen;
    int last_k_cyc;
    bit gap_pending;
    int dones;
    logic prev_xrd, prev_ofrd, prev_pwr;

    corelet_ctrl #(.row(ROW), .col(COL), .tile(TILE), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .p_base(p_base), .len(len),
        .l0_full(l0_full), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic build_model(input int unsigned w, input int unsigned a,
                               input int unsigned p, input int unsigned n);
        int unsigned off, m;
        exp_q.delete();
        for (int unsigned k = 0; k < ROW; k++) exp_q.push_back('{EV_R, (w + k) % AMOD});
        for (int unsigned k = 0; k < ROW; k++) exp_q.push_back('{EV_K, 0});
        off = 0;
        while (off < n) begin
            m = (n - off > TILE) ? TILE : n - off;
            for (int unsigned i = 0; i < m; i++) exp_q.push_back('{EV_R, (a + off + i) % AMOD});
            for (int unsigned i = 0; i < m; i++) exp_q.push_back('{EV_E, 0});
            for (int unsigned i = 0; i < m; i++) exp_q.push_back('{EV_W, (p + off + i) % AMOD});
            off += m;
        end
    endtask

    task automatic pop_expect(input logic [7:0] kind, input int unsigned addr);
        tok_t t;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {56'd0, kind}, 64'd0);
        end else begin
            t = exp_q.pop_front();
            check("event_kind", {56'd0, kind}, {56'd0, t.kind});
            if (kind == EV_R || kind == EV_W) check("event_addr", addr, t.addr);
        end
    endtask

    task automatic sample_cycle();
        logic xrd, l0wr, ofrd, pwr;
        xrd  = ~inst[19];
        l0wr = inst[2];
        ofrd = inst[6];
        pwr  = ~inst[32] & ~inst[31];
        check("xmem_wen_high", inst[18], 1'b1);
        check("l0_wr_after_xmem_rd", l0wr, prev_xrd);
        check("pmem_wr_after_ofifo_rd", pwr, prev_ofrd);
        check("unused_bits_low", inst[5:4], 2'b00);
        if (ofrd) check("ofifo_rd_needs_valid", ofifo_valid, 1'b1);
`ifdef CORELET_CTRL_SFP_ACC_EN
        check("sfp_acc_after_write", inst[33], prev_pwr);
`else
        check("sfp_acc_tied_low", inst[33], 1'b0);
`endif
        if (xrd) begin
            if (gap_pending) begin
                check("flush_gap_to_aload", cyc, last_k_cyc + COL + 1);
                gap_pending = 0;
            end
            pop_expect(EV_R, inst[17:7]);
        end else begin
            check("a_xmem_idle", inst[17:7], 11'd0);
        end
        if (inst[0]) begin
            check("kload_l0_rd", inst[3], 1'b1);
            pop_expect(EV_K, 0);
            kseen++;
            if (kseen == ROW) begin
                last_k_cyc  = cyc;
                gap_pending = 1;
            end
        end
        if (inst[1]) begin
            check("exec_l0_rd", inst[3], 1'b1);
            pop_expect(EV_E, 0);
        end
        if (pwr) pop_expect(EV_W, inst[30:20]);
        else check("a_pmem_idle", inst[30:20], 11'd0);
        if (done) begin
            dones++;
            if (gap_pending) begin
                check("flush_gap_to_done", cyc, last_k_cyc + COL + 1);
                gap_pending = 0;
            end
        end
        prev_xrd  = xrd;
        prev_ofrd = ofrd;
        prev_pwr  = pwr;
    endtask

    // vmode: 0 = ofifo_valid high, 1 = random, 2 = pattern 1,0,0
    task automatic run_pass(input int unsigned w, input int unsigned a, input int unsigned p,
                            input int unsigned n, input int vmode, input bit full,
                            input bit restart, input bit abort_exec);
        bit restart_now, restart_done;
        build_model(w, a, p, n);
        prev_xrd = 0; prev_ofrd = 0; prev_pwr = 0;
        kseen = 0; gap_pending = 0; dones = 0;
        restart_now = 0; restart_done = 0;
        @(negedge clk);
        w_base = ABW'(w); a_base = ABW'(a); p_base = ABW'(p); len = ABW'(n);
        start = 1'b1; l0_full = full; ofifo_valid = 1'b0;
        #1 check("idle_before_start", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        w_base = ABW'($urandom); a_base = ABW'($urandom);
        p_base = ABW'($urandom); len = ABW'($urandom);
        cyc = 0;
        while (cyc < BUDGET) begin
            start = restart_now;
            restart_now = 0;
            case (vmode)
                0:       ofifo_valid = 1'b1;
                1:       ofifo_valid = 1'($urandom_range(0, 1));
                default: ofifo_valid = (cyc % 3 == 0);
            endcase
            #1;
            if (cyc == 0) check("err_cleared_on_start", err, 1'b0);
            if (!full) check("err_stays_low", err, 1'b0);
            check("busy_in_pass", busy, 1'b1);
            sample_cycle();
            if (restart && !restart_done && !inst[32]) begin
                restart_now  = 1;
                restart_done = 1;
            end
            if (abort_exec && inst[1]) break;
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("pass_within_budget", cyc < BUDGET, 1'b1);
        if (abort_exec) begin
            reset = 1'b1;
            #1;
            check("abort_inst_idle", inst, IDLE_WORD);
            check("abort_busy_low", busy, 1'b0);
            check("abort_no_done", done, 1'b0);
            @(negedge clk);
            #1 check("abort_held_idle", inst, IDLE_WORD);
            reset = 1'b0;
            repeat (6) begin
                @(negedge clk);
                #1;
                check("no_done_after_abort", done, 1'b0);
                check("idle_after_abort", busy, 1'b0);
            end
            exp_q.delete();
        end else begin
            check("busy_at_done", busy, 1'b1);
            check("err_at_done", err, full);
            check("all_events_seen", exp_q.size(), 0);
            @(negedge clk);
            #1;
            check("busy_after_done", busy, 1'b0);
            check("idle_word_after_done", inst, IDLE_WORD);
            check("single_done_pulse", done, 1'b0);
            check("err_sticky_after_done", err, full);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; a_base = '0; p_base = '0; len = '0;
        @(negedge clk);
        #1;
        check("reset_inst", inst, IDLE_WORD);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        start = 1'b1;
        @(negedge clk);
        #1 check("start_during_reset_ignored", busy, 1'b0);
        start = 1'b0;
        reset = 1'b0;

        run_pass(0, 16, 0, 4, 0, 1'b0, 1'b0, 1'b0);
        run_pass(0, 16, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_pass($urandom, $urandom, 0, 150, 1, 1'b0, 1'b0, 1'b0);
        run_pass($urandom, $urandom, $urandom, 10, 2, 1'b0, 1'b0, 1'b0);
        run_pass(5, 40, 100, 20, 0, 1'b0, 1'b0, 1'b1);
        run_pass(0, 16, 0, 4, 0, 1'b0, 1'b0, 1'b0);
        run_pass(3, 30, 7, 6, 1, 1'b1, 1'b1, 1'b0);
        run_pass($urandom, $urandom, $urandom, 7, 1, 1'b0, 1'b1, 1'b0);
        run_pass(2044, 2040, 2045, 12, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            run_pass($urandom, $urandom, $urandom, $urandom_range(0, 90), 1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
